// File: rtl/mac_dataflow_pkg.sv
// Shared types and defaults for the mac_dataflow multiply / multiply-accumulate engine.
package mac_dataflow_pkg;

  localparam int DEF_MAC_CNT_LEN = 4096;

  typedef enum logic [1:0] {
    MODE_MULT  = 2'd0,
    MODE_ACC   = 2'd1,
    MODE_ACC_C = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_C = 3'd1,
    S_RUN    = 3'd2,
    S_FLUSH  = 3'd3,
    S_OUT    = 3'd4
  } state_t;

endpackage

// File: rtl/mac_dataflow_if.sv
// Operand (a, b, c) and result (d) streams of mac_dataflow, seen from the streamer (master) and the engine (slave).
interface mac_dataflow_if #(
  parameter int DATA_W = 32
);
  logic              a_TVALID;
  logic              a_TREADY;
  logic [DATA_W-1:0] a_TDATA;
  logic              b_TVALID;
  logic              b_TREADY;
  logic [DATA_W-1:0] b_TDATA;
  logic              c_TVALID;
  logic              c_TREADY;
  logic [DATA_W-1:0] c_TDATA;
  logic              d_TVALID;
  logic              d_TREADY;
  logic [DATA_W-1:0] d_TDATA;

  modport master (
    output a_TVALID, a_TDATA, b_TVALID, b_TDATA, c_TVALID, c_TDATA, d_TREADY,
    input  a_TREADY, b_TREADY, c_TREADY, d_TVALID, d_TDATA
  );

  modport slave (
    input  a_TVALID, a_TDATA, b_TVALID, b_TDATA, c_TVALID, c_TDATA, d_TREADY,
    output a_TREADY, b_TREADY, c_TREADY, d_TVALID, d_TDATA
  );
endinterface

// File: rtl/mac_dataflow_shift_sat.sv
// Arithmetic right shift of a wide signed value, then clip (sat) or truncate to DATA_W bits.
module mac_dataflow_shift_sat #(
  parameter int IN_W    = 77,
  parameter int DATA_W  = 32,
  parameter int SHIFT_W = 5
) (
  input  logic signed [IN_W-1:0]    i_value,
  input  logic        [SHIFT_W-1:0] i_shift,
  input  logic                      i_sat,
  output logic        [DATA_W-1:0]  o_data
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

  logic signed [IN_W-1:0] w_shifted;

  assign w_shifted = i_value >>> i_shift;

  // NOTE: every path assigns o_data, so this stays purely combinational (no latch).
  always_comb begin
    if (i_sat && (w_shifted > MAX_V)) begin
      o_data = MAX_V[DATA_W-1:0];
    end else if (i_sat && (w_shifted < MIN_V)) begin
      o_data = MIN_V[DATA_W-1:0];
    end else begin
      o_data = w_shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/mac_dataflow.sv
// Stream multiply / multiply-accumulate engine: jobs launched by start, results on the d stream.
module mac_dataflow
  import mac_dataflow_pkg::*;
#(
  parameter  int DATA_W      = 32,
  parameter  int MAC_CNT_LEN = DEF_MAC_CNT_LEN,
  localparam int CNT_W       = $clog2(MAC_CNT_LEN) + 1,
  localparam int SHIFT_W     = $clog2(DATA_W),
  localparam int ACC_W       = 2*DATA_W + CNT_W
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  mac_dataflow_if.slave      s,
  input  logic               start,
  input  logic [1:0]         reg_mode,
  input  logic [SHIFT_W-1:0] reg_shift,
  input  logic [CNT_W-1:0]   reg_len,
  input  logic               reg_sat,
  output logic               busy,
  output logic               done
);

  state_t                     r_state, w_next_state;
  mode_t                      r_mode;
  logic        [SHIFT_W-1:0]  r_shift;
  logic        [CNT_W-1:0]    r_len;
  logic                       r_sat;
  logic        [CNT_W-1:0]    r_in_cnt;
  logic        [CNT_W-1:0]    r_out_cnt;
  logic signed [2*DATA_W-1:0] r_mult;
  logic                       r_mult_valid;
  logic signed [ACC_W-1:0]    r_acc;

  logic                       w_is_mult;
  logic                       w_pipe_ready;
  logic                       w_ab_fire;
  logic                       w_c_fire;
  logic                       w_d_fire;
  logic                       w_last_in;
  logic                       w_last_out;
  logic        [CNT_W-1:0]    w_len_eff;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_mult_ext;
  logic signed [ACC_W-1:0]    w_c_ext;
  logic signed [ACC_W-1:0]    w_ss_in;
  logic        [DATA_W-1:0]   w_ss_out;

  assign w_is_mult  = (r_mode == MODE_MULT) || (r_mode == MODE_RSVD);
  assign w_last_in  = (r_in_cnt == r_len - CNT_W'(1));
  assign w_last_out = (r_out_cnt == r_len - CNT_W'(1));
  assign w_prod     = $signed({{DATA_W{s.a_TDATA[DATA_W-1]}}, s.a_TDATA}) *
                      $signed({{DATA_W{s.b_TDATA[DATA_W-1]}}, s.b_TDATA});
  assign w_mult_ext = {{(ACC_W-2*DATA_W){r_mult[2*DATA_W-1]}}, r_mult};
  assign w_c_ext    = {{(ACC_W-DATA_W){s.c_TDATA[DATA_W-1]}}, s.c_TDATA};

  // A zero length still runs one product; oversize requests clamp to the counter range.
  always_comb begin
    if (reg_len == '0) begin
      w_len_eff = CNT_W'(1);
    end else if (reg_len > CNT_W'(MAC_CNT_LEN)) begin
      w_len_eff = CNT_W'(MAC_CNT_LEN);
    end else begin
      w_len_eff = reg_len;
    end
  end

  always_comb begin
    w_next_state = r_state;
    s.a_TREADY   = 1'b0;
    s.b_TREADY   = 1'b0;
    s.c_TREADY   = 1'b0;
    s.d_TVALID   = 1'b0;
    done         = 1'b0;
    busy         = (r_state != S_IDLE);
    w_pipe_ready = w_is_mult ? (s.d_TREADY | ~r_mult_valid) : 1'b1;
    w_ab_fire    = 1'b0;
    w_c_fire     = 1'b0;
    w_d_fire     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = (mode_t'(reg_mode) == MODE_ACC_C) ? S_LOAD_C : S_RUN;
        end
      end
      S_LOAD_C: begin
        s.c_TREADY = 1'b1;
        w_c_fire   = s.c_TVALID;
        if (w_c_fire) w_next_state = S_RUN;
      end
      S_RUN: begin
        w_ab_fire  = w_pipe_ready & s.a_TVALID & s.b_TVALID & (r_in_cnt < r_len);
        s.a_TREADY = w_ab_fire;
        s.b_TREADY = w_ab_fire;
        if (w_is_mult) begin
          s.d_TVALID = r_mult_valid;
          w_d_fire   = r_mult_valid & s.d_TREADY;
          if (w_d_fire && w_last_out) begin
            done         = 1'b1;
            w_next_state = S_IDLE;
          end
        end else if (w_ab_fire && w_last_in) begin
          w_next_state = S_FLUSH;
        end
      end
      S_FLUSH: w_next_state = S_OUT;
      S_OUT: begin
        s.d_TVALID = 1'b1;
        w_d_fire   = s.d_TREADY;
        if (w_d_fire) begin
          done         = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_ss_in = (r_state == S_OUT) ? r_acc : w_mult_ext;

  mac_dataflow_shift_sat #(
    .IN_W    (ACC_W),
    .DATA_W  (DATA_W),
    .SHIFT_W (SHIFT_W)
  ) u_shift_sat (
    .i_value (w_ss_in),
    .i_shift (r_shift),
    .i_sat   (r_sat),
    .o_data  (w_ss_out)
  );

  assign s.d_TDATA = s.d_TVALID ? w_ss_out : '0;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state      <= S_IDLE;
      r_mode       <= MODE_MULT;
      r_shift      <= '0;
      r_len        <= '0;
      r_sat        <= 1'b0;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_mult       <= '0;
      r_mult_valid <= 1'b0;
      r_acc        <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && start) begin
        r_mode       <= mode_t'(reg_mode);
        r_shift      <= reg_shift;
        r_len        <= w_len_eff;
        r_sat        <= reg_sat;
        r_in_cnt     <= '0;
        r_out_cnt    <= '0;
        r_acc        <= '0;
        r_mult_valid <= 1'b0;
      end
      if (w_c_fire) r_acc <= w_c_ext <<< r_shift;
      // In ACC modes the product register drains into acc every cycle.
      if (w_ab_fire) begin
        r_mult       <= w_prod;
        r_mult_valid <= 1'b1;
        r_in_cnt     <= r_in_cnt + CNT_W'(1);
      end else if (!w_is_mult || w_d_fire) begin
        r_mult_valid <= 1'b0;
      end
      if (w_d_fire && r_state == S_RUN) r_out_cnt <= r_out_cnt + CNT_W'(1);
      if (!w_is_mult && r_mult_valid && (r_state == S_RUN || r_state == S_FLUSH)) begin
        r_acc <= r_acc + w_mult_ext;
      end
    end
  end

`ifndef SYNTHESIS
  a_d_stall_stable: assert property (@(posedge ap_clk) disable iff (ap_rst)
    (s.d_TVALID && !s.d_TREADY) |=> (s.d_TVALID && $stable(s.d_TDATA)));
  a_mult_stall_stable: assert property (@(posedge ap_clk) disable iff (ap_rst)
    (r_state == S_RUN && w_is_mult && r_mult_valid && !s.d_TREADY)
      |=> (r_mult_valid && $stable(r_mult)));
`endif

endmodule

// File: tb/tb_mac_dataflow.sv
// Self-checking bench for mac_dataflow: directed jobs plus randomized MULT streams against an arithmetic model.
module tb_mac_dataflow;
  localparam int DATA_W      = 32;
  localparam int MAC_CNT_LEN = 4096;
  localparam int CNT_W       = $clog2(MAC_CNT_LEN) + 1;
  localparam int SHIFT_W     = $clog2(DATA_W);
  localparam longint SMAX    = 64'sd2147483647;
  localparam longint SMIN    = -SMAX - 64'sd1;

  logic               ap_clk;
  logic               ap_rst;
  logic               start;
  logic [1:0]         reg_mode;
  logic [SHIFT_W-1:0] reg_shift;
  logic [CNT_W-1:0]   reg_len;
  logic               reg_sat;
  logic               busy;
  logic               done;

  mac_dataflow_if #(.DATA_W(DATA_W)) st ();

  mac_dataflow #(.DATA_W(DATA_W), .MAC_CNT_LEN(MAC_CNT_LEN)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .s         (st),
    .start     (start),
    .reg_mode  (reg_mode),
    .reg_shift (reg_shift),
    .reg_len   (reg_len),
    .reg_sat   (reg_sat),
    .busy      (busy),
    .done      (done)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int          va[$];
  int          vb[$];
  int          vc;
  logic [31:0] exp_d[$];
  logic [31:0] got_d[$];
  int          got_cyc[$];
  int          in_cyc[$];
  int          done_cyc[$];
  int          first_dv;

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ref_out(input longint v, input int sh, input bit sat);
    longint r;
    r = v >>> sh;
    if (sat && r > SMAX) r = SMAX;
    if (sat && r < SMIN) r = SMIN;
    return r[31:0];
  endfunction

  // Expected d values for n pairs: one per product (MULT) or one total (ACC / ACC_C).
  function automatic void model_job(input int mode, input int sh, input bit sat, input int n);
    longint acc;
    exp_d.delete();
    if (mode == 1 || mode == 2) begin
      acc = (mode == 2) ? (longint'(vc) <<< sh) : 0;
      for (int i = 0; i < n; i++) acc += longint'(va[i]) * longint'(vb[i]);
      exp_d.push_back(ref_out(acc, sh, sat));
    end else begin
      for (int i = 0; i < n; i++) exp_d.push_back(ref_out(longint'(va[i]) * longint'(vb[i]), sh, sat));
    end
  endfunction

  task automatic idle_inputs();
    start       = 1'b0;
    st.a_TVALID = 1'b0;
    st.b_TVALID = 1'b0;
    st.c_TVALID = 1'b0;
    st.a_TDATA  = '0;
    st.b_TDATA  = '0;
    st.c_TDATA  = '0;
    st.d_TREADY = 1'b0;
  endtask

  // Launches one job (caller is just after a rising edge) and streams va/vb/vc until done.
  task automatic run_job(input int mode, input int sh, input bit sat, input int len_reg,
                         input int n_pairs, input bit rnd);
    int          ai, outst;
    bit          a_v, b_v, c_v, prev_stall, fin;
    logic [31:0] prev_d;
    got_d.delete(); got_cyc.delete(); in_cyc.delete(); done_cyc.delete();
    first_dv  = -1;
    start     = 1'b1;
    reg_mode  = 2'(mode);
    reg_shift = SHIFT_W'(sh);
    reg_len   = CNT_W'(len_reg);
    reg_sat   = sat;
    @(posedge ap_clk); #1;
    start     = 1'b0;
    reg_mode  = 2'($urandom);
    reg_shift = SHIFT_W'($urandom);
    reg_len   = CNT_W'($urandom);
    reg_sat   = 1'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL busy_after_start got=%0b exp=1", busy);
    end
    ai = 0; outst = 0; a_v = 0; b_v = 0; c_v = (mode == 2); prev_stall = 0; fin = 0; prev_d = '0;
    for (int k = 0; k < 2000 && !fin; k++) begin
      if (!a_v && ai < n_pairs) a_v = !rnd || ($urandom_range(0, 3) != 0);
      if (!b_v && ai < n_pairs) b_v = !rnd || ($urandom_range(0, 3) != 0);
      st.a_TVALID = a_v;
      st.b_TVALID = b_v;
      st.a_TDATA  = (ai < n_pairs) ? va[ai] : 0;
      st.b_TDATA  = (ai < n_pairs) ? vb[ai] : 0;
      st.c_TVALID = c_v;
      st.c_TDATA  = vc;
      st.d_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge ap_clk);
      if (st.a_TREADY !== st.b_TREADY) begin
        checks++; failures++;
        $display("FAIL joint_ready a=%0b b=%0b", st.a_TREADY, st.b_TREADY);
      end
      if (rnd && (mode == 0) && outst >= 1 && !st.d_TREADY) begin
        checks++;
        if (st.a_TREADY !== 1'b0) begin
          failures++; $display("FAIL ready_while_full got=%0b exp=0", st.a_TREADY);
        end
      end
      if (prev_stall) begin
        checks++;
        if (st.d_TVALID !== 1'b1 || st.d_TDATA !== prev_d) begin
          failures++;
          $display("FAIL d_stall_stable got=%0b/%0h exp=1/%0h", st.d_TVALID, st.d_TDATA, prev_d);
        end
      end
      if (st.a_TREADY === 1'b1 && a_v && b_v) begin
        in_cyc.push_back(cyc); ai++; a_v = 0; b_v = 0; outst++;
      end
      if (st.c_TREADY === 1'b1 && c_v) c_v = 0;
      if (st.d_TVALID === 1'b1 && first_dv < 0) first_dv = cyc;
      if (st.d_TVALID === 1'b1 && st.d_TREADY) begin
        got_d.push_back(st.d_TDATA); got_cyc.push_back(cyc); outst--;
      end
      prev_stall = (st.d_TVALID === 1'b1) && !st.d_TREADY;
      prev_d     = st.d_TDATA;
      if (done === 1'b1) begin
        done_cyc.push_back(cyc); fin = 1;
      end
      @(posedge ap_clk); #1;
    end
    idle_inputs();
    checks++;
    if (!fin) begin
      failures++; $display("FAIL job_timeout got=no_done exp=done");
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL busy_after_done got=%0b exp=0", busy);
    end
  endtask

  task automatic compare_outputs(input string name);
    checks++;
    if (got_d.size() != exp_d.size()) begin
      failures++; $display("FAIL %s_count got=%0d exp=%0d", name, got_d.size(), exp_d.size());
    end else begin
      for (int i = 0; i < exp_d.size(); i++) begin
        checks++;
        if (got_d[i] !== exp_d[i]) begin
          failures++; $display("FAIL %s_d[%0d] got=%0h exp=%0h", name, i, got_d[i], exp_d[i]);
        end
      end
    end
    checks++;
    if (done_cyc.size() != 1 || got_cyc.size() == 0 || done_cyc[0] != got_cyc[got_cyc.size()-1]) begin
      failures++;
      $display("FAIL %s_done_timing got=%0d pulses exp=1 on last d", name, done_cyc.size());
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reg_mode = '0; reg_shift = '0; reg_len = '0; reg_sat = 1'b0;
    ap_rst = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    st.a_TVALID = 1'b1; st.b_TVALID = 1'b1; st.c_TVALID = 1'b1; st.d_TREADY = 1'b1;
    @(negedge ap_clk);
    checks++;
    if ({busy, done, st.a_TREADY, st.b_TREADY, st.c_TREADY, st.d_TVALID} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%06b exp=000000",
               {busy, done, st.a_TREADY, st.b_TREADY, st.c_TREADY, st.d_TVALID});
    end
    checks++;
    if (st.d_TDATA !== '0) begin
      failures++; $display("FAIL reset_d_data got=%0h exp=0", st.d_TDATA);
    end
    @(posedge ap_clk); #1;
    idle_inputs();
  endtask

  task automatic test_mult_basic();
    va = '{2, -3, 7}; vb = '{5, 4, -1};
    run_job(0, 0, 0, 3, 3, 0);
    model_job(0, 0, 0, 3);
    compare_outputs("mult_basic");
    for (int i = 0; i < 3 && i < got_cyc.size() && i < in_cyc.size(); i++) begin
      checks++;
      if (got_cyc[i] != in_cyc[i] + 1 || got_cyc[i] != got_cyc[0] + i) begin
        failures++;
        $display("FAIL mult_latency[%0d] got=%0d exp=%0d", i, got_cyc[i], in_cyc[0] + 1 + i);
      end
    end
  endtask

  task automatic test_mult_sat();
    va = '{32'h4000_0000}; vb = '{32'h4000_0000};
    run_job(0, 0, 1, 1, 1, 0);
    model_job(0, 0, 1, 1);
    compare_outputs("mult_sat");
    run_job(0, 0, 0, 1, 1, 0);
    model_job(0, 0, 0, 1);
    compare_outputs("mult_trunc");
  endtask

  task automatic test_acc();
    va = '{1, 2, 3, 4}; vb = '{1, 1, 1, 1};
    run_job(1, 0, 0, 4, 4, 0);
    model_job(1, 0, 0, 4);
    compare_outputs("acc");
    checks++;
    if (in_cyc.size() != 4 || first_dv != in_cyc[3] + 2) begin
      failures++;
      $display("FAIL acc_latency got=%0d exp=last_in+2", first_dv);
    end
  endtask

  task automatic test_acc_c();
    vc = -5; va = '{3, 3}; vb = '{4, 4};
    run_job(2, 2, 0, 2, 2, 0);
    model_job(2, 2, 0, 2);
    compare_outputs("acc_c");
  endtask

  task automatic test_len_and_mode();
    va = '{9, 8, 7}; vb = '{-2, 3, 4};
    run_job(0, 0, 0, 0, 3, 0);
    model_job(0, 0, 0, 1);
    compare_outputs("len_zero");
    run_job(3, 1, 0, 2, 3, 0);
    model_job(3, 1, 0, 2);
    compare_outputs("mode_rsvd");
  endtask

  task automatic test_mult_random();
    for (int r = 0; r < 4; r++) begin
      int  sh;
      bit  sat;
      va.delete(); vb.delete();
      for (int i = 0; i < 16; i++) begin
        va.push_back(int'($urandom));
        vb.push_back((r == 0) ? int'($urandom_range(0, 200)) - 100 : int'($urandom));
      end
      sh  = $urandom_range(0, 31);
      sat = 1'($urandom_range(0, 1));
      run_job(0, sh, sat, 16, 16, 1);
      model_job(0, sh, sat, 16);
      compare_outputs("mult_random");
    end
  endtask

  task automatic test_back_to_back();
    va = '{5, -6}; vb = '{7, 7};
    run_job(1, 0, 1, 2, 2, 0);
    model_job(1, 0, 1, 2);
    compare_outputs("b2b_first");
    va = '{-100000, 3}; vb = '{100000, 3};
    run_job(1, 3, 1, 2, 2, 0);
    model_job(1, 3, 1, 2);
    compare_outputs("b2b_second");
  endtask

  task automatic test_reset_mid_job();
    int saw_done;
    saw_done = 0;
    start = 1'b1; reg_mode = 2'd1; reg_shift = '0; reg_len = CNT_W'(4); reg_sat = 1'b0;
    @(posedge ap_clk); #1;
    start = 1'b0;
    st.a_TVALID = 1'b1; st.b_TVALID = 1'b1; st.a_TDATA = 11; st.b_TDATA = 13; st.d_TREADY = 1'b1;
    repeat (2) begin
      @(negedge ap_clk);
      if (done === 1'b1) saw_done++;
      @(posedge ap_clk); #1;
    end
    ap_rst = 1'b1;
    @(negedge ap_clk);
    if (done === 1'b1) saw_done++;
    @(posedge ap_clk); #1;
    checks++;
    if ({busy, done, st.a_TREADY, st.b_TREADY, st.c_TREADY, st.d_TVALID} !== 6'b0 || st.d_TDATA !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%06b/%0h exp=000000/0",
               {busy, done, st.a_TREADY, st.b_TREADY, st.c_TREADY, st.d_TVALID}, st.d_TDATA);
    end
    ap_rst = 1'b0;
    @(negedge ap_clk);
    if (done === 1'b1) saw_done++;
    checks++;
    if (st.a_TREADY !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL idle_unaccepted got=%0b/%0b exp=0/0", st.a_TREADY, busy);
    end
    @(posedge ap_clk); #1;
    idle_inputs();
    checks++;
    if (saw_done != 0) begin
      failures++; $display("FAIL reset_no_done got=%0d exp=0", saw_done);
    end
    va = '{6}; vb = '{7};
    run_job(1, 0, 0, 1, 1, 0);
    model_job(1, 0, 0, 1);
    compare_outputs("after_reset");
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    test_mult_sat();
    test_acc();
    test_acc_c();
    test_len_and_mode();
    test_mult_random();
    test_back_to_back();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
